// File: rtl/fft_control_pkg.sv
// Shared constants for the FFT framing block and a helper sizing the frame index.
package fft_control_pkg;

    localparam int DATA_W  = 14;
    localparam int FFT_PTS = 512;
    localparam int PTS_W   = 10;

    function automatic int idx_width(input int pts);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < pts) w = i + 1;
        end
        return w;
    endfunction

    localparam int IDX_W = idx_width(FFT_PTS);

endpackage

// File: rtl/fft_control_if.sv
// ADC sample input plus Avalon-ST sink bus of the FFT core; master is the framer side.
interface fft_control_if
    import fft_control_pkg::*;
();
    logic signed [DATA_W-1:0] in_signal;
    logic                     sink_ready;
    logic                     sink_valid;
    logic                     sink_sop;
    logic                     sink_eop;
    logic [1:0]               sink_error;
    logic                     inverse;
    logic signed [DATA_W-1:0] out_real;
    logic signed [DATA_W-1:0] out_imag;
    logic [PTS_W-1:0]         fft_pts;

    modport master (
        input  in_signal, sink_ready,
        output sink_valid, sink_sop, sink_eop, sink_error,
               inverse, out_real, out_imag, fft_pts
    );

    modport slave (
        output in_signal, sink_ready,
        input  sink_valid, sink_sop, sink_eop, sink_error,
               inverse, out_real, out_imag, fft_pts
    );
endinterface

// File: rtl/fft_frame_counter.sv
// Sample index within an FFT frame; sop/eop decoded from the registered index.
// Latency: markers follow the registered index; holds while adv is low.
module fft_frame_counter
    import fft_control_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic adv,
    input  logic vld,
    output logic sop,
    output logic eop
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_PTS - 1);

    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;

    // The first sample accepted after reset always opens a new frame.
    always_comb begin
        idx_d = idx_q;
        if (adv) begin
            if (!vld)                  idx_d = '0;
            else if (idx_q == LAST_IDX) idx_d = '0;
            else                       idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) idx_q <= '0;
        else       idx_q <= idx_d;
    end

    assign sop = vld && (idx_q == '0);
    assign eop = vld && (idx_q == LAST_IDX);

endmodule

// File: rtl/fft_control.sv
// Frames the continuous ADC stream into FFT_PTS-sample packets for the FFT core; 1 cycle latency.
// Backpressure: presented sample and markers hold while sink_ready is low; new inputs are dropped.
module fft_control
    import fft_control_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    fft_control_if.master bus
);
    logic                     adv;
    logic                     sink_valid_q;
    logic                     sink_valid_d;
    logic signed [DATA_W-1:0] out_real_q;
    logic signed [DATA_W-1:0] out_real_d;

    always_comb begin
        adv          = !sink_valid_q || bus.sink_ready;
        sink_valid_d = sink_valid_q;
        out_real_d   = out_real_q;
        if (adv) begin
            sink_valid_d = 1'b1;
            out_real_d   = bus.in_signal;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sink_valid_q <= 1'b0;
            out_real_q   <= '0;
        end else begin
            sink_valid_q <= sink_valid_d;
            out_real_q   <= out_real_d;
        end
    end

    fft_frame_counter u_frame_counter (
        .clk   (clk),
        .reset (reset),
        .adv   (adv),
        .vld   (sink_valid_q),
        .sop   (bus.sink_sop),
        .eop   (bus.sink_eop)
    );

    assign bus.sink_valid = sink_valid_q;
    assign bus.out_real   = out_real_q;
    // Real-only input, forward transform, fixed frame size.
    assign bus.out_imag   = '0;
    assign bus.sink_error = 2'b00;
    assign bus.inverse    = 1'b0;
    assign bus.fft_pts    = PTS_W'(FFT_PTS);

endmodule

// File: tb/tb_fft_control.sv
// Testbench for fft_control: directed vector table plus framing, stall, wrap and reset sequences.
module tb_fft_control;
    import fft_control_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;

    fft_control_if ifc ();

    fft_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.master)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic [13:0] din;
        logic        vld;
        logic        sop;
        logic        eop;
        logic [13:0] real_v;
    } vec_t;

    vec_t vecs [12];

    // Reference state: presented sample, index and valid.
    logic        m_vld  = 1'b0;
    int          m_idx  = 0;
    logic [13:0] m_real = '0;

    int xfers    = 0;
    int sop_xfer = 0;
    bit have_sop = 1'b0;
    int v        = 0;
    int nsop     = 0;
    int neop     = 0;
    logic [13:0] held;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_static();
        check("fft_pts",    {22'd0, ifc.fft_pts}, 32'd512);
        check("inverse",    {31'd0, ifc.inverse}, 32'd0);
        check("sink_error", {30'd0, ifc.sink_error}, 32'd0);
        check("out_imag",   {18'd0, ifc.out_imag}, 32'd0);
    endtask

    task automatic tick(input logic r, input logic rd, input logic [13:0] d);
        reset          = r;
        ifc.sink_ready = rd;
        ifc.in_signal  = d;
        if (r) begin
            have_sop = 1'b0;
        end else if (ifc.sink_valid && rd) begin
            xfers++;
            if (ifc.sink_sop) begin
                if (have_sop) check("frame_len", xfers - sop_xfer, 32'd512);
                sop_xfer = xfers;
                have_sop = 1'b1;
            end
            if (ifc.sink_eop && have_sop) check("eop_pos", xfers - sop_xfer + 1, 32'd512);
        end
        @(posedge clk);
        #1;
        if (r) begin
            m_vld  = 1'b0;
            m_idx  = 0;
            m_real = '0;
        end else if (!m_vld || rd) begin
            m_idx  = m_vld ? (m_idx + 1) % FFT_PTS : 0;
            m_vld  = 1'b1;
            m_real = d;
        end
        check("valid",    {31'd0, ifc.sink_valid}, {31'd0, m_vld});
        check("out_real", {18'd0, ifc.out_real}, {18'd0, m_real});
        check("sop",      {31'd0, ifc.sink_sop}, {31'd0, (m_vld && m_idx == 0)});
        check("eop",      {31'd0, ifc.sink_eop}, {31'd0, (m_vld && m_idx == FFT_PTS - 1)});
        check("sop_eop_excl", {31'd0, (ifc.sink_sop & ifc.sink_eop)}, 32'd0);
        check_static();
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 14'd5,     1'b0, 1'b0, 1'b0, 14'd0};
        vecs[1]  = '{1'b1, 1'b1, 14'd5,     1'b0, 1'b0, 1'b0, 14'd0};
        vecs[2]  = '{1'b1, 1'b1, 14'd5,     1'b0, 1'b0, 1'b0, 14'd0};
        vecs[3]  = '{1'b0, 1'b1, 14'd7,     1'b1, 1'b1, 1'b0, 14'd7};
        vecs[4]  = '{1'b0, 1'b0, 14'd8,     1'b1, 1'b1, 1'b0, 14'd7};
        vecs[5]  = '{1'b0, 1'b0, 14'd9,     1'b1, 1'b1, 1'b0, 14'd7};
        vecs[6]  = '{1'b0, 1'b1, 14'h2000,  1'b1, 1'b0, 1'b0, 14'h2000};
        vecs[7]  = '{1'b0, 1'b1, 14'h1fff,  1'b1, 1'b0, 1'b0, 14'h1fff};
        vecs[8]  = '{1'b1, 1'b0, 14'd3,     1'b0, 1'b0, 1'b0, 14'd0};
        vecs[9]  = '{1'b0, 1'b0, 14'd4,     1'b1, 1'b1, 1'b0, 14'd4};
        vecs[10] = '{1'b0, 1'b0, 14'd6,     1'b1, 1'b1, 1'b0, 14'd4};
        vecs[11] = '{1'b0, 1'b1, 14'd2,     1'b1, 1'b0, 1'b0, 14'd2};

        for (int i = 0; i < 12; i++) begin
            reset          = vecs[i].rst;
            ifc.sink_ready = vecs[i].rdy;
            ifc.in_signal  = vecs[i].din;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid", i), {31'd0, ifc.sink_valid}, {31'd0, vecs[i].vld});
            check($sformatf("vec%0d_sop", i),   {31'd0, ifc.sink_sop},   {31'd0, vecs[i].sop});
            check($sformatf("vec%0d_eop", i),   {31'd0, ifc.sink_eop},   {31'd0, vecs[i].eop});
            check($sformatf("vec%0d_real", i),  {18'd0, ifc.out_real},   {18'd0, vecs[i].real_v});
            check_static();
        end

        // Ramp with ready held high across two frame boundaries.
        tick(1'b1, 1'b1, 14'd0);
        v = 0;
        for (int i = 0; i < 1100; i++) begin
            tick(1'b0, 1'b1, 14'(v));
            v++;
            if (ifc.sink_sop) begin
                check("ramp_sop_val", {18'd0, ifc.out_real}, 32'(512 * nsop));
                nsop++;
            end
            if (ifc.sink_eop) begin
                check("ramp_eop_val", {18'd0, ifc.out_real}, 32'(511 + 512 * neop));
                neop++;
            end
        end
        check("ramp_sop_count", 32'(nsop), 32'd3);
        check("ramp_eop_count", 32'(neop), 32'd2);

        // Stall five cycles at index 100.
        for (int i = 0; i < 600; i++) begin
            if (m_vld && m_idx == 100) break;
            tick(1'b0, 1'b1, 14'(v));
            v++;
        end
        held = ifc.out_real;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, 14'(v));
            v++;
            check("stall_hold", {18'd0, ifc.out_real}, {18'd0, held});
        end
        tick(1'b0, 1'b1, 14'(v));
        check("resume_val", {18'd0, ifc.out_real}, 32'(v));
        v++;

        // Stall on the last sample of a frame.
        for (int i = 0; i < 600; i++) begin
            if (m_vld && m_idx == FFT_PTS - 1) break;
            tick(1'b0, 1'b1, 14'(v));
            v++;
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 14'(v));
            v++;
            check("eop_hold", {31'd0, ifc.sink_eop}, 32'd1);
        end
        tick(1'b0, 1'b1, 14'(v));
        v++;
        check("sop_after_eop", {31'd0, ifc.sink_sop}, 32'd1);

        // Reset mid-frame at index 300.
        for (int i = 0; i < 600; i++) begin
            if (m_vld && m_idx == 300) break;
            tick(1'b0, 1'b1, 14'(v));
            v++;
        end
        tick(1'b1, 1'b1, 14'(v));
        v++;
        check("midreset_valid", {31'd0, ifc.sink_valid}, 32'd0);
        tick(1'b0, 1'b1, 14'(v));
        v++;
        check("midreset_sop", {31'd0, ifc.sink_sop}, 32'd1);
        neop = 0;
        for (int i = 0; i < 600; i++) begin
            tick(1'b0, 1'b1, 14'(v));
            v++;
            if (ifc.sink_eop) neop++;
        end
        check("eop_after_reset", 32'(neop), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fft_control.md
Name: fft_control

Overview:
- Avalon-ST source that frames a continuous real-valued ADC sample stream into fixed-length packets for a downstream variable-streaming FFT core.
- Registers each input sample onto the FFT sink interface and drives the imaginary part to zero.
- Generates start/end-of-packet markers every FFT_PTS accepted samples and supplies the constant point count, direction and error fields the core expects.
- Sits between the ADC sample bus and the FFT core inside the FFT wrapper.

Parameters:
- DATA_W, 14, sample width (in_signal, out_real, out_imag).
- FFT_PTS, 512, points per FFT frame; must be a power of two, at least 2 and at most 2^(PTS_W-1).
- PTS_W, 10, width of the fft_pts output.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_signal  in  DATA_W  signed two's-complement input sample, valid every cycle.
- sink_ready  in  1  FFT core ready; ready latency 0.
- sink_valid  out  1  sample on out_real/out_imag is valid.
- sink_sop  out  1  first sample of frame.
- sink_eop  out  1  last sample of frame.
- sink_error  out  2  constant 2'b00.
- inverse  out  1  constant 0 (forward FFT).
- out_real  out  DATA_W  registered sample.
- out_imag  out  DATA_W  constant 0.
- fft_pts  out  PTS_W  constant FFT_PTS.

Behaviour:
- Registers:
  - out_real (DATA_W).
  - sink_valid (1).
  - idx, the index of the presented sample, log2(FFT_PTS) bits.
- Reset (sync, high), values on the next edge: sink_valid=0, idx=0, out_real=0. sop and eop are therefore 0.
- Advance condition: adv = !sink_valid || sink_ready. Evaluated each cycle with reset low.
- On adv:
  - out_real <= in_signal.
  - sink_valid <= 1.
  - idx <= 0 if sink_valid was 0; otherwise idx <= (idx==FFT_PTS-1) ? 0 : idx+1.
- When adv=0 (valid high, ready low): out_real, idx and sink_valid hold. The presented sample and markers stay stable; input samples arriving meanwhile are dropped.
- A transfer occurs on any edge where sink_valid && sink_ready.
- sink_sop = sink_valid && idx==0, combinational from registers.
- sink_eop = sink_valid && idx==FFT_PTS-1, combinational from registers.
- Latency: in_signal sampled at edge k appears on out_real after edge k (1 cycle).
- First valid sample after reset release: presented 1 cycle after the first edge with reset low, with sop=1.
- Wrap-around: the transfer with eop=1 returns idx to 0; the next presented sample carries sop=1. There is no gap between frames.
- sop and eop are never asserted together (FFT_PTS>=2).
- Reset mid-frame: the partial frame is abandoned and framing restarts at idx=0. The FFT core must be reset alongside.
- sink_valid never deasserts after reset, apart from the initial post-reset cycle.
- Constant outputs (sink_error, inverse, out_imag, fft_pts) are independent of reset.

Decomposition:
- Shared package: DATA_W, FFT_PTS, PTS_W constants, plus a function computing log2(FFT_PTS) for the idx width.
- Natural sub-module: fft_frame_counter. It holds idx with advance/valid inputs and has sop/eop outputs.
- The top level holds the sample register and the constant ties.

Test Plan:
1. Reset held 3 cycles, sink_ready=1 → sink_valid=0, sop=0, eop=0, out_real=0. On the first cycle after release, sink_valid=1 and sop=1 with out_real equal to the in_signal from the previous edge.
2. Ramp in_signal 0,1,2,… with ready=1, FFT_PTS=512:
   - out_real lags input by 1 cycle.
   - sop on samples 0, 512, 1024.
   - eop on samples 511, 1023.
   - No cycle has both.
3. Drop ready for 5 cycles at idx=100 → out_real, idx and sop/eop frozen. On re-assertion idx continues at 101 with the value present at the next edge; exactly 512 transfers between successive sops.
4. Ready low exactly on the eop cycle (idx=511) → eop stays high until the transfer, then sop=1 on the next cycle.
5. Assert reset at idx=300 for 1 cycle → sink_valid=0, then a new frame begins with sop=1. The following eop comes after 512 transfers.
6. Static checks: fft_pts=512, inverse=0, sink_error=2'b00, out_imag=0 throughout. Negative input 14'h2000 passes through unchanged.
